// File: rtl/div_result_stage.sv
// Sequencer and result stage behind the combinational 32-bit divider: holds operands for a
// settle window, sign-corrects the raw magnitudes into Z (ZHI = remainder, ZLO = quotient).
module div_result_stage #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] dividend_in,
  input  logic [31:0] divisor_in,
  output logic [31:0] op_dividend,
  output logic [31:0] op_divisor,
  input  logic [63:0] div_raw,
  output logic [31:0] zhi_out,
  output logic [31:0] zlo_out,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic        div_by_zero
);

  localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);
  localparam logic [31:0] IntMin = 32'h8000_0000;
  localparam logic [31:0] AllOnes = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StSettle, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op_dividend_q, op_dividend_d;
  logic [31:0] op_divisor_q, op_divisor_d;
  logic [31:0] zhi_q, zhi_d;
  logic [31:0] zlo_q, zlo_d;
  logic        dbz_q, dbz_d;
  logic        sq_q, sq_d;
  logic        sr_q, sr_d;

  logic accept, div_zero, overflow, sample;
  logic [31:0] raw_quot, raw_rem;

  always_comb begin
    accept   = (state_q == StIdle) && start;
    div_zero = (divisor_in == 32'd0);
    overflow = (dividend_in == IntMin) && (divisor_in == AllOnes);
    sample   = (state_q == StSettle) && (cnt_q == 4'd0);
    raw_quot = div_raw[31:0];
    raw_rem  = div_raw[63:32];
  end

  // State register
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; zero divisor and INT_MIN/-1 bypass the divider entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (div_zero || overflow) ? StDone : StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    result_valid = (state_q == StDone);
    busy         = (state_q != StIdle);
    op_dividend  = op_dividend_q;
    op_divisor   = op_divisor_q;
    zhi_out      = zhi_q;
    zlo_out      = zlo_q;
    div_by_zero  = dbz_q;
  end

  // Datapath next-state: operand latch, settle counter, result correction
  always_comb begin
    op_dividend_d = op_dividend_q;
    op_divisor_d  = op_divisor_q;
    cnt_d         = cnt_q;
    zhi_d         = zhi_q;
    zlo_d         = zlo_q;
    dbz_d         = dbz_q;
    sq_d          = sq_q;
    sr_d          = sr_q;

    if (accept) begin
      op_dividend_d = dividend_in;
      op_divisor_d  = divisor_in;
      sq_d          = dividend_in[31] ^ divisor_in[31];
      sr_d          = dividend_in[31];
      if (div_zero) begin
        zhi_d = dividend_in;
        zlo_d = AllOnes;
        dbz_d = 1'b1;
      end else if (overflow) begin
        zhi_d = 32'd0;
        zlo_d = IntMin;
        dbz_d = 1'b0;
      end else begin
        cnt_d = CntInit;
      end
    end

    if (state_q == StSettle) begin
      if (sample) begin
        // Quotient sign from both operands, remainder sign from the dividend
        zlo_d = sq_q ? (32'd0 - raw_quot) : raw_quot;
        zhi_d = sr_q ? (32'd0 - raw_rem) : raw_rem;
        dbz_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      op_dividend_q <= 32'd0;
      op_divisor_q  <= 32'd0;
      cnt_q         <= 4'd0;
      zhi_q         <= 32'd0;
      zlo_q         <= 32'd0;
      dbz_q         <= 1'b0;
      sq_q          <= 1'b0;
      sr_q          <= 1'b0;
    end else begin
      op_dividend_q <= op_dividend_d;
      op_divisor_q  <= op_divisor_d;
      cnt_q         <= cnt_d;
      zhi_q         <= zhi_d;
      zlo_q         <= zlo_d;
      dbz_q         <= dbz_d;
      sq_q          <= sq_d;
      sr_q          <= sr_d;
    end
  end

endmodule
